// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: one producer, four independent consumers,
// each channel backed by a one-entry holding register and an accepted-word counter.
module demux1to4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              s0,
    input  logic              s1,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);

    logic [1:0]        sel;
    logic              in_fire;
    logic [3:0]        load;
    logic [3:0]        valid_q;
    logic [DATA_W-1:0] data_q [4];
    logic [CNT_W-1:0]  cnt_q  [4];

    assign sel      = {s1, s0};
    // A full channel can still take a word if its consumer drains on the same edge.
    assign in_ready = ~valid_q[sel] | out_ready[sel];
    assign in_fire  = in_valid & in_ready;
    assign load     = in_fire ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                    cnt_q[i]   <= cnt_q[i] + 1'b1;
                end else if (valid_q[i] && out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];
    assign cnt3      = cnt_q[3];

endmodule
